// File: rtl/rvvi_cmd_decoder_if.sv
// rtl/rvvi_cmd_decoder_if.sv - Ethernet RX AXI-stream bundle feeding the host-command decoder
//
// Purpose: groups the four RX stream signals so the decoder takes one port.
// Signals:
//   RvviAxiRdata   32  RX stream data word
//   RvviAxiRstrb    4  byte strobes for RvviAxiRdata
//   RvviAxiRlast    1  last word of the current frame
//   RvviAxiRvalid   1  word valid; the stream has no ready, every valid word is consumed
// Modports: master drives the stream (RX MAC side), slave consumes it (decoder).

interface rvvi_cmd_decoder_if;
   logic [31:0] RvviAxiRdata;
   logic [3:0]  RvviAxiRstrb;
   logic        RvviAxiRlast;
   logic        RvviAxiRvalid;

   modport master (output RvviAxiRdata, output RvviAxiRstrb, output RvviAxiRlast, output RvviAxiRvalid);
   modport slave  (input  RvviAxiRdata, input  RvviAxiRstrb, input  RvviAxiRlast, input  RvviAxiRvalid);
endinterface

// File: rtl/rvvi_cmd_decoder.sv
// rtl/rvvi_cmd_decoder.sv - multi-channel host-command decoder on the tracer's Ethernet RX stream
//
// Purpose: checks the MAC/EtherType header of each RX frame, matches the 48-bit command tag
// against NUM_CMDS tags and captures PAYLOAD_WORDS payload words into the matching channel.
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   rx            RX stream (rvvi_cmd_decoder_if.slave): data, strobes, last, valid
//   CmdValid      one-cycle pulse per completed command, one bit per channel
//   CmdPayload    held payload; channel i at [i*PAYLOAD_WORDS*32 +: PAYLOAD_WORDS*32], word0 in LSBs
//   FrameDropped  one-cycle pulse when a frame with a matched header/tag ends before its payload
//   CmdHitCount   (RVVI_CMD_STATS_EN only) 16-bit saturating per-channel command counters
//   DropCount     (RVVI_CMD_STATS_EN only) 16-bit saturating dropped-frame counter
// Optional feature: define RVVI_CMD_STATS_EN to add the statistics counters.

module rvvi_cmd_decoder #(
   parameter int                       NUM_CMDS      = 4,
   parameter int                       PAYLOAD_WORDS = 1,
   parameter logic [47:0]              DST_MAC       = 48'h8F54_0000_1654,
   parameter logic [47:0]              SRC_MAC       = 48'h4502_1111_6843,
   parameter logic [15:0]              ETH_TYPE      = 16'h005C,
   parameter logic [NUM_CMDS*48-1:0]   CMD_TAGS      = {48'h1234_5678_7274, 48'h6574_6172_7465,
                                                        48'h6E77_6F64_6C73, 48'h6E69_6769_7274}
) (
   input  logic                                  clk,
   input  logic                                  reset,
   rvvi_cmd_decoder_if.slave                     rx,
   output logic [NUM_CMDS-1:0]                   CmdValid,
   output logic [NUM_CMDS*PAYLOAD_WORDS*32-1:0]  CmdPayload,
`ifdef RVVI_CMD_STATS_EN
   output logic                                  FrameDropped,
   output logic [NUM_CMDS*16-1:0]                CmdHitCount,
   output logic [15:0]                           DropCount
`else
   output logic                                  FrameDropped
`endif
);

   localparam int PW32 = PAYLOAD_WORDS * 32;

   typedef enum logic [2:0] {IDLE, HDR, TAG, PAY, DRAIN} state_t;

   state_t               state, nextState;
   logic [2:0]           wordCnt, nextCnt;
   logic [NUM_CMDS-1:0]  candMask, nextMask;
   logic [NUM_CMDS-1:0]  selOh, nextSel;
   logic [PW32-1:0]      shadow, stageNext;
   logic [NUM_CMDS-1:0]  tagLoHit, tagHiHit;
   logic                 strbOk, hdrOk, lastPay, commit, drop;

   assign strbOk = (rx.RvviAxiRstrb == 4'hF);

   // w3 carries TAG[15:0] in its upper half, w4 carries TAG[47:16].
   always_comb begin
      tagLoHit = '0;
      tagHiHit = '0;
      for (int i = 0; i < NUM_CMDS; i++) begin
         tagLoHit[i] = (rx.RvviAxiRdata[31:16] == CMD_TAGS[48*i +: 16]);
         tagHiHit[i] = (rx.RvviAxiRdata == CMD_TAGS[48*i+16 +: 32]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      nextCnt   = wordCnt;
      nextMask  = candMask;
      nextSel   = selOh;
      stageNext = shadow;
      hdrOk     = 1'b0;
      commit    = 1'b0;
      drop      = 1'b0;
      lastPay   = (wordCnt == 3'(PAYLOAD_WORDS - 1));
      if (rx.RvviAxiRvalid) begin
         nextCnt = wordCnt + 3'd1;
         case (state)
            IDLE: begin
               hdrOk     = (rx.RvviAxiRdata == DST_MAC[31:0]);
               nextState = (strbOk && hdrOk) ? HDR : DRAIN;
            end
            HDR: begin
               case (wordCnt)
                  3'd1:    hdrOk = (rx.RvviAxiRdata == {SRC_MAC[15:0], DST_MAC[47:32]});
                  3'd2:    hdrOk = (rx.RvviAxiRdata == SRC_MAC[47:16]);
                  default: hdrOk = (rx.RvviAxiRdata[15:0] == ETH_TYPE) && (|tagLoHit);
               endcase
               nextMask = tagLoHit;
               if (!(strbOk && hdrOk))  nextState = DRAIN;
               else if (wordCnt == 3'd3) nextState = TAG;
            end
            TAG: begin
               nextMask  = candMask & tagHiHit;
               // isolate the lowest set bit so duplicate tags resolve to the lowest channel
               nextSel   = nextMask & (~nextMask + NUM_CMDS'(1));
               // from here on the counter indexes payload words, not frame words
               nextCnt   = 3'd0;
               nextState = (strbOk && (|nextMask)) ? PAY : DRAIN;
            end
            PAY: begin
               for (int w = 0; w < PAYLOAD_WORDS; w++)
                  if (wordCnt == 3'(w)) stageNext[w*32 +: 32] = rx.RvviAxiRdata;
               if (!strbOk) begin
                  drop      = 1'b1;
                  nextState = DRAIN;
               end else if (lastPay) begin
                  commit    = 1'b1;
                  nextState = DRAIN;
               end else if (rx.RvviAxiRlast) begin
                  drop      = 1'b1;
               end
            end
            DRAIN: ;
            default: nextState = IDLE;
         endcase
         // end of frame overrides every other transition
         if (rx.RvviAxiRlast) begin
            nextState = IDLE;
            nextCnt   = 3'd0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wordCnt      <= 3'd0;
         candMask     <= '0;
         selOh        <= '0;
         shadow       <= '0;
         CmdValid     <= '0;
         CmdPayload   <= '0;
         FrameDropped <= 1'b0;
      end else begin
         wordCnt      <= nextCnt;
         candMask     <= nextMask;
         selOh        <= nextSel;
         shadow       <= stageNext;
         CmdValid     <= commit ? selOh : '0;
         FrameDropped <= drop;
         if (commit) begin
            for (int i = 0; i < NUM_CMDS; i++)
               if (selOh[i]) CmdPayload[i*PW32 +: PW32] <= stageNext;
         end
      end
   end

`ifdef RVVI_CMD_STATS_EN
   logic [NUM_CMDS*16-1:0] hitCnt;
   logic [15:0]            dropCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         hitCnt  <= '0;
         dropCnt <= 16'd0;
      end else begin
         for (int i = 0; i < NUM_CMDS; i++)
            if (CmdValid[i] && (hitCnt[i*16 +: 16] != 16'hFFFF))
               hitCnt[i*16 +: 16] <= hitCnt[i*16 +: 16] + 16'd1;
         if (FrameDropped && (dropCnt != 16'hFFFF))
            dropCnt <= dropCnt + 16'd1;
      end
   end

   assign CmdHitCount = hitCnt;
   assign DropCount   = dropCnt;
`endif

endmodule
